// File: rtl/result_uart_tx.sv
// result_uart_tx: on a rising edge of start, reads NUM_WORDS 16-bit words from a
// synchronous result buffer and sends each word as two 8N1 UART bytes (high byte
// first). busy covers the whole transfer; finish holds until start drops.
//
// Handshake: rd_en is a one-cycle read strobe with rd_addr valid in the same
// cycle; the buffer must present rd_data exactly one cycle later. There is no
// back-pressure. start is a level, and only its 0->1 transition seen in IDLE is
// acted upon.
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_WORDS    = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              tx,
  output logic              busy,
  output logic              finish,
  output logic [2:0]        dbg_state
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   WORD_LAST = (ADDR_W + 1)'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT      = 3'd2,
    START_BIT = 3'd3,
    DATA      = 3'd4,
    STOP      = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t            state, state_n;
  logic              start_q;
  // armed goes high once start has been seen low, so a level held high through
  // reset release is never mistaken for a fresh request.
  logic              armed, armed_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic              hi_byte, hi_byte_n;
  logic [ADDR_W:0]   word_idx, word_idx_n;
  logic [15:0]       shreg, shreg_n;
  logic              tx_n, busy_n, finish_n, rd_en_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic [7:0]        cur_byte_n;
  logic              trigger;

  assign dbg_state = state;
  assign trigger   = start & ~start_q & armed;

  // State and registered outputs; every output line comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      armed    <= 1'b0;
      baud     <= '0;
      bit_idx  <= '0;
      hi_byte  <= 1'b0;
      word_idx <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      finish   <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
    end else begin
      state    <= state_n;
      start_q  <= start;
      armed    <= armed_n;
      baud     <= baud_n;
      bit_idx  <= bit_idx_n;
      hi_byte  <= hi_byte_n;
      word_idx <= word_idx_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      busy     <= busy_n;
      finish   <= finish_n;
      rd_en    <= rd_en_n;
      rd_addr  <= rd_addr_n;
    end
  end

  // Next-state logic plus the next values of all registered outputs.
  always_comb begin
    state_n    = state;
    armed_n    = armed | ~start;
    baud_n     = baud;
    bit_idx_n  = bit_idx;
    hi_byte_n  = hi_byte;
    word_idx_n = word_idx;
    shreg_n    = shreg;
    busy_n     = busy;
    finish_n   = finish;

    case (state)
      IDLE: begin
        if (trigger) begin
          word_idx_n = '0;
          busy_n     = 1'b1;
          state_n    = FETCH;
        end
      end
      FETCH: state_n = WAIT;
      WAIT: begin
        shreg_n   = rd_data;
        hi_byte_n = 1'b1;
        baud_n    = '0;
        state_n   = START_BIT;
      end
      START_BIT: begin
        if (baud == BAUD_LAST) begin
          baud_n    = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else bit_idx_n = bit_idx + 1'b1;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (hi_byte) begin
            hi_byte_n = 1'b0;
            state_n   = START_BIT;
          end else begin
            word_idx_n = word_idx + 1'b1;
            if (word_idx != WORD_LAST) begin
              state_n = FETCH;
            end else begin
              busy_n   = 1'b0;
              finish_n = 1'b1;
              state_n  = DONE;
            end
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DONE: begin
        if (!start) begin
          finish_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are derived from the state being entered so they line up with it.
    rd_en_n    = (state_n == FETCH);
    rd_addr_n  = (state_n == FETCH) ? word_idx_n[ADDR_W-1:0] : rd_addr;
    cur_byte_n = hi_byte_n ? shreg_n[15:8] : shreg_n[7:0];
    case (state_n)
      START_BIT: tx_n = 1'b0;
      DATA:      tx_n = cur_byte_n[bit_idx_n];
      default:   tx_n = 1'b1;
    endcase
  end

endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868; clock cycles per UART bit (100 MHz / 115200 baud); legal range >= 2.
REQ-002 SHALL have parameter NUM_WORDS, default 16; number of result words sent per transfer; legal range >= 1.
REQ-003 SHALL have parameter ADDR_W, default 4; result-buffer address width; 2**ADDR_W >= NUM_WORDS.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port start  input  1  transfer request level from the compute core; a 0->1 transition is the trigger.
REQ-007 SHALL have port rd_en  output  1  result-buffer read strobe, one cycle per word.
REQ-008 SHALL have port rd_addr  output  ADDR_W  result-buffer word address.
REQ-009 SHALL have port rd_data  input  16  result word; valid exactly one cycle after the rd_en cycle.
REQ-010 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-011 SHALL have port busy  output  1  high from trigger until DONE is entered.
REQ-012 SHALL have port finish  output  1  transfer-complete level.

Function
REQ-013 SHALL implement states IDLE, FETCH, WAIT, START_BIT, DATA, STOP, DONE.
REQ-014 SHALL register start and detect a rising edge only in IDLE; a start held high from reset SHALL NOT trigger until it goes low then high.
REQ-015 SHALL, on trigger in IDLE, clear the word index to 0, set busy and go to FETCH.
REQ-016 FETCH: rd_en=1 for exactly one cycle, rd_addr=word index; next state WAIT.
REQ-017 WAIT: capture rd_data into a 16-bit shift register; select high byte first; next state START_BIT.
REQ-018 START_BIT: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: 8 bits of the current byte, LSB first, each CLKS_PER_BIT cycles; then STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles; after the high byte go to START_BIT for the low byte; after the low byte increment the index and go to FETCH if index < NUM_WORDS, else DONE.
REQ-021 tx SHALL be 1 in IDLE, FETCH, WAIT, DONE; each word therefore costs exactly 20*CLKS_PER_BIT+2 cycles.
REQ-022 The baud counter SHALL count 0..CLKS_PER_BIT-1 and restart at every bit boundary; no drift across bytes.
REQ-023 DONE: busy=0, finish=1; remain until start is low, then go to IDLE with finish=0 in the same transition.
REQ-024 start edges while not in IDLE SHALL be ignored; no queued retrigger.
REQ-025 tx SHALL come directly from a flop (glitch-free line).
REQ-026 rd_addr SHALL hold its last value outside FETCH; rd_en SHALL be 0 outside FETCH.

Reset
REQ-027 rst high SHALL asynchronously force IDLE, tx=1, busy=0, finish=0, rd_en=0, rd_addr=0, counters and shift register 0, registered start=0.
REQ-028 rst asserted mid-byte SHALL abort immediately with tx=1; after release no transmission resumes until a new start edge.

Verification (CLKS_PER_BIT=4, NUM_WORDS=2)
REQ-029 Buffer {0xA55A, 0x0103}, start pulsed 0->1 and held -> rd_en at addr 0 then addr 1; tx bytes 0xA5, 0x5A, 0x01, 0x03 decoded LSB first; finish=1 exactly 164 cycles after trigger edge.
REQ-030 start held high from reset release -> no rd_en and tx stays 1 for 200 cycles; then start low, high -> normal transfer.
REQ-031 After finish=1, start kept high 50 cycles -> finish stays 1, tx=1; start low -> next cycle finish=0, state IDLE.
REQ-032 Extra start toggles during bit 3 of byte 2 -> output byte stream unchanged, exactly one finish.
REQ-033 rst pulsed for 1 cycle during DATA of byte 1 -> tx=1 and busy=0 within that cycle, finish never asserts; subsequent start edge -> full correct stream from addr 0.
REQ-034 Bench SHALL check every start-bit low period equals exactly 4 cycles and every stop bit is 1.
